// File: rtl/multicyc_dmem_resp_pkg.sv
// rtl/multicyc_dmem_resp_pkg.sv - FSM encodings, limits and access-check helper for multicyc_dmem_resp
package multicyc_dmem_resp_pkg;

  // FSM state encodings (2-bit, kept as plain constants for legacy compatibility)
  localparam logic [1:0] DMEM_IDLE = 2'd0;
  localparam logic [1:0] DMEM_WAIT = 2'd1;
  localparam logic [1:0] DMEM_DONE = 2'd2;

  // Wait-state limits: the counter is sized for the largest allowed WAIT_CYCLES
  localparam int DMEM_WAIT_MAX = 15;
  localparam int DMEM_WAIT_W   = 4;

  // Default byte address of word 0
  localparam logic [31:0] DMEM_BASE_DEFAULT = 32'h0000_0000;

  // Individual reasons an access is refused at commit
  typedef struct packed {
    logic misaligned;
    logic outOfRange;
    logic conflict;
  } dmemChk_t;

  // Classify an access; off is addr-base, span is the window size in bytes
  function automatic dmemChk_t dmemCheck(
    input logic [31:0] addr,
    input logic [31:0] base,
    input logic [31:0] off,
    input logic [31:0] span,
    input logic        rd,
    input logic        wr
  );
    dmemChk_t c;
    c.misaligned = (addr[1:0] != 2'b00);
    // off wraps when addr is below base, so both bounds are tested explicitly
    c.outOfRange = (addr < base) || (off >= span);
    c.conflict   = rd & wr;
    return c;
  endfunction

endpackage

// File: rtl/multicyc_dmem_resp_if.sv
// rtl/multicyc_dmem_resp_if.sv - core-to-data-memory bus with ready/error handshake
interface multicyc_dmem_resp_if;

  logic [31:0] iAddr;
  logic        iMemRead;
  logic        iMemWrite;
  logic [31:0] iWrData;
  logic [31:0] oRdData;
  logic        oReady;
  logic        oErr;

  // Core side: issues requests and holds them until oReady
  modport master (
    output iAddr, iMemRead, iMemWrite, iWrData,
    input  oRdData, oReady, oErr
  );

  // Memory side: the responder
  modport slave (
    input  iAddr, iMemRead, iMemWrite, iWrData,
    output oRdData, oReady, oErr
  );

endinterface

// File: rtl/multicyc_dmem_ram.sv
// rtl/multicyc_dmem_ram.sv - single-port DEPTH x 32 synchronous RAM with registered read port
module multicyc_dmem_ram #(
  parameter int DEPTH = 256
) (
  input  logic                     iClk,
  input  logic                     iRst_n,
  input  logic                     iWe,
  input  logic                     iRe,
  input  logic                     iClr,
  input  logic [$clog2(DEPTH)-1:0] iIdx,
  input  logic [31:0]              iWrData,
  output logic [31:0]              oRdData
);

  logic [31:0] mem [DEPTH];

  // Array write; contents survive reset on purpose
  always_ff @(posedge iClk) begin
    if (iWe) begin
      mem[iIdx] <= iWrData;
    end
  end

  // Read register: cleared on refused accesses, otherwise holds until the next good read
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      oRdData <= '0;
    end else if (iClr) begin
      oRdData <= '0;
    end else if (iRe) begin
      oRdData <= mem[iIdx];
    end
  end

endmodule

// File: rtl/multicyc_dmem_resp.sv
// rtl/multicyc_dmem_resp.sv - multi-cycle data-memory responder; DMEM_STATS_EN adds oRdCnt/oWrCnt
module multicyc_dmem_resp
  import multicyc_dmem_resp_pkg::*;
#(
  parameter int          DEPTH       = 256,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = DMEM_BASE_DEFAULT
) (
  input logic               iClk,
  input logic               iRst_n,
  multicyc_dmem_resp_if.slave bus
`ifdef DMEM_STATS_EN
  ,
  output logic [15:0]       oRdCnt,
  output logic [15:0]       oWrCnt
`endif
);

  localparam int                     IDX_W     = $clog2(DEPTH);
  localparam logic [31:0]            SPAN      = 32'(4 * DEPTH);
  localparam logic [DMEM_WAIT_W-1:0] WAIT_LOAD =
    (WAIT_CYCLES > 0) ? DMEM_WAIT_W'(WAIT_CYCLES - 1) : '0;

  logic [1:0]             state;
  logic [DMEM_WAIT_W-1:0] waitCnt;
  logic                   req;
  logic                   commit;
  logic [31:0]            offset;
  dmemChk_t               chk;
  logic                   accErr;
  logic [IDX_W-1:0]       idx;
  logic                   ramWe;
  logic                   ramRe;
  logic                   ramClr;
  logic                   readyReg;
  logic                   errReg;

  assign req = bus.iMemRead | bus.iMemWrite;

  // Address decode; BASE_ADDR is window-aligned so the word index is a plain slice of the offset
  always_comb begin
    offset = bus.iAddr - BASE_ADDR;
    chk    = dmemCheck(bus.iAddr, BASE_ADDR, offset, SPAN, bus.iMemRead, bus.iMemWrite);
    accErr = |chk;
    idx    = offset[IDX_W+1:2];
  end

  // Commit fires on the edge that enters DONE; the request is re-sampled there
  always_comb begin
    commit = 1'b0;
    case (state)
      DMEM_IDLE: commit = req && (WAIT_CYCLES == 0);
      DMEM_WAIT: commit = req && (waitCnt == '0);
      default:   commit = 1'b0;
    endcase
  end

  // RAM strobes: refused accesses touch neither the array nor stale read data
  always_comb begin
    ramWe  = commit & bus.iMemWrite & ~accErr;
    ramRe  = commit & bus.iMemRead & ~accErr;
    ramClr = commit & accErr;
  end

  // Access sequencing IDLE -> WAIT* -> DONE, back to IDLE when the core withdraws mid-wait
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state   <= DMEM_IDLE;
      waitCnt <= '0;
    end else begin
      case (state)
        DMEM_IDLE: begin
          if (req) begin
            if (WAIT_CYCLES == 0) begin
              state <= DMEM_DONE;
            end else begin
              state   <= DMEM_WAIT;
              waitCnt <= WAIT_LOAD;
            end
          end
        end
        DMEM_WAIT: begin
          if (!req) begin
            state   <= DMEM_IDLE;
            waitCnt <= '0;
          end else if (waitCnt == '0) begin
            state <= DMEM_DONE;
          end else begin
            waitCnt <= waitCnt - 1'b1;
          end
        end
        DMEM_DONE: state <= DMEM_IDLE;
        default:   state <= DMEM_IDLE;
      endcase
    end
  end

  // Completion pulse and error flag; oErr can only be high alongside oReady
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      readyReg <= 1'b0;
      errReg   <= 1'b0;
    end else begin
      readyReg <= commit;
      errReg   <= commit & accErr;
    end
  end

  assign bus.oReady = readyReg;
  assign bus.oErr   = errReg;

  multicyc_dmem_ram #(
    .DEPTH (DEPTH)
  ) uRam (
    .iClk    (iClk),
    .iRst_n  (iRst_n),
    .iWe     (ramWe),
    .iRe     (ramRe),
    .iClr    (ramClr),
    .iIdx    (idx),
    .iWrData (bus.iWrData),
    .oRdData (bus.oRdData)
  );

`ifdef DMEM_STATS_EN
  // Saturating counts of clean completions; refused and withdrawn accesses never reach ramRe/ramWe
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      oRdCnt <= '0;
      oWrCnt <= '0;
    end else begin
      if (ramRe && (oRdCnt != 16'hFFFF)) begin
        oRdCnt <= oRdCnt + 16'd1;
      end
      if (ramWe && (oWrCnt != 16'hFFFF)) begin
        oWrCnt <= oWrCnt + 16'd1;
      end
    end
  end
`else
  // Statistics counters are not built in this configuration
`endif

endmodule

// File: doc/multicyc_dmem_resp.md
Name: multicyc_dmem_resp

Overview:
- Data-memory responder: the slave end of the core's data-memory port (address / MemRead / MemWrite / WrData / RdData).
- Adds a ready/error handshake so the core can stall on multi-cycle memory.
- Word-addressed RAM with configurable wait states, address-range and alignment checks.
- Sits between the core's MEM stage and the on-chip data RAM.

Parameters:
- DEPTH, 256, number of 32-bit words; must be a power of two.
- WAIT_CYCLES, 2, extra wait states per access (0..15).
- BASE_ADDR, 32'h0000_0000, byte address of word 0; 4*DEPTH-aligned.

Ports:
- iClk  in  1  clock
- iRst_n  in  1  asynchronous active-low reset
- iAddr  in  32  byte address, held stable until oReady
- iMemRead  in  1  read request level
- iMemWrite  in  1  write request level
- iWrData  in  32  write data, held stable until oReady
- oRdData  out  32  registered read data
- oReady  out  1  one-cycle completion pulse
- oErr  out  1  error flag, valid only with oReady

Behaviour:
- Clock is iClk; reset is asynchronous, active-low on iRst_n.
- Reset values: state=IDLE, wait count=0, oReady=0, oErr=0, oRdData=0. RAM contents are not affected by reset; simulation initialises them to 0.
- FSM states: IDLE, WAIT, DONE.
  - IDLE: if (iMemRead|iMemWrite) and WAIT_CYCLES>0, load count=WAIT_CYCLES-1 and go to WAIT. If WAIT_CYCLES==0, go directly to DONE.
  - WAIT: decrement count each cycle; at count==0 go to DONE.
  - DONE: oReady=1 for exactly this cycle, then go to IDLE.
- Latency: request seen in IDLE at cycle t gives oReady at cycle t+WAIT_CYCLES+1.
- Abort: if both request lines drop while in WAIT, return to IDLE next cycle. No write occurs, no oReady, oRdData unchanged.
- Commit: the request is sampled again on the edge entering DONE.
  - Write: RAM[idx] <= iWrData on that edge.
  - Read: oRdData <= RAM[idx] on that edge.
- Index: idx = (iAddr-BASE_ADDR)[log2(DEPTH)+1:2].
- Error conditions (checked at commit): any of
  - iAddr[1:0]!=0
  - iAddr<BASE_ADDR or iAddr>=BASE_ADDR+4*DEPTH
  - iMemRead&iMemWrite both asserted
- On error: no RAM write, oRdData <= 0, oErr=1 together with oReady.
- oErr=0 whenever oReady=0.
- oRdData holds its value between transactions.
- Back-to-back: IDLE in the cycle after DONE accepts a new request, giving a minimum 1-cycle bubble. The core must deassert, or present the next request, in the cycle after oReady.
- Reset mid-transaction: the FSM returns to IDLE immediately and a pending write is discarded.
- Read-after-write to the same word in consecutive transactions returns the new data.

Optional Feature:
- Macro: DMEM_STATS_EN.
- Defined:
  - Adds output ports oRdCnt[15:0] and oWrCnt[15:0].
  - Each counter increments on a successful (oErr=0) DONE of its type.
  - Counters saturate at 16'hFFFF and reset to 0.
  - Errored and aborted transactions are not counted.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared include mem_define.v, alongside isa_define.v, holds:
  - FSM state encodings DMEM_IDLE/WAIT/DONE (2-bit).
  - WAIT_CYCLES maximum constant.
  - Default BASE_ADDR.
- One natural sub-module: multicyc_dmem_ram.
  - Single-port synchronous RAM with DEPTH x 32 words, iWe, iIdx, iWrData, oRdData registered.
- The FSM and address checks stay in the top module.

Test Plan:
- WAIT_CYCLES=2, write 32'hDEADBEEF to 0x10, then read 0x10 → oReady 3 cycles after each request, oErr=0, oRdData=32'hDEADBEEF.
- Read at 0x13 (misaligned) → oReady after 3 cycles, oErr=1, oRdData=0; a subsequent read of 0x10 still returns 32'hDEADBEEF.
- DEPTH=256, write to 0x400 (out of range) → oErr=1; reads of words 0 and 255 are unchanged.
- Write 0x20 with value 1, drop iMemWrite after 1 cycle of WAIT → no oReady; a later read of 0x20 returns its old value.
- WAIT_CYCLES=0, back-to-back reads of 0x0, 0x4, 0x8 → oReady every 2nd cycle with the correct data; iRst_n asserted low mid-WAIT → oReady=0 immediately and state=IDLE.
- DMEM_STATS_EN defined: 3 good reads, 2 good writes, 1 errored read → oRdCnt=3, oWrCnt=2.
